// File: rtl/pipe_pkg.sv
// pipe_pkg: widths, opcodes, control/hazard vector bit indices for the 16-bit pipeline
package pipe_pkg;
  localparam int REG_AW = 4;
  localparam int CV_W = 11;
  localparam int HZ_W = 13;
  localparam logic [15:0] NOP_INSTR = 16'hF000;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_LW = 4'h2;
  localparam logic [3:0] OP_SW = 4'h3;
  localparam logic [3:0] OP_JMPZ = 4'h4;
  localparam logic [3:0] OP_MOVI = 4'h5;
  localparam logic [3:0] OP_FADD = 4'h6;
  localparam logic [3:0] OP_STOP = 4'hE;
  localparam logic [3:0] OP_NOP = 4'hF;
  localparam int CV_REG_WRITE = 10;
  localparam int CV_ALU_SUB = 9;
  localparam int CV_BRANCH = 8;
  localparam int CV_MEM_READ = 7;
  localparam int CV_REG_DST_RT = 6;
  localparam int CV_MEM_WRITE = 5;
  localparam int CV_RSVD = 4;
  localparam int CV_MEM_TO_REG = 3;
  localparam int CV_MOV_IMM = 2;
  localparam int CV_FLOAT_OP = 1;
  localparam int CV_STOP = 0;
  localparam logic [CV_W-1:0] CV_NOP = '0;
  localparam logic [CV_W-1:0] CV_ADD_C = 11'h400;
  localparam logic [CV_W-1:0] CV_SUB_C = 11'h600;
  localparam logic [CV_W-1:0] CV_LW_C = 11'h4C8;
  localparam logic [CV_W-1:0] CV_SW_C = 11'h020;
  localparam logic [CV_W-1:0] CV_JMPZ_C = 11'h300;
  localparam logic [CV_W-1:0] CV_STOP_C = 11'h001;
  localparam int HZ_ALU_SRC1 = 11;
  localparam int HZ_ALU_SRC2 = 9;
  localparam int HZ_MEM_SRC = 8;
  localparam int HZ_FLUSH_EX_MEM = 7;
  localparam int HZ_FLUSH_IF_ID = 6;
  localparam int HZ_FLUSH_ID_EX = 5;
  localparam int HZ_PCSTALL = 4;
  localparam int HZ_IF_ID_STALL = 3;
  localparam int HZ_ID_EX_STALL = 2;
  localparam int HZ_EX_MEM_STALL = 1;
  localparam int HZ_MEM_WB_STALL = 0;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline register with priority rst > flush > stall > bubble > advance
module pipe_stage_reg #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] BUB_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? RST_VAL : flush ? BUB_VAL : stall ? q : bubble ? BUB_VAL : d;
endmodule

// File: rtl/pipe_hazard_regs.sv
// pipe_hazard_regs: IF/ID..MEM/WB control/tag registers with hazard stall/flush and stop latch; PERF_CNT_EN adds retire/bubble counters
module pipe_hazard_regs
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr_i,
  input  logic [CV_W-1:0]   control_vector_i,
  input  logic [HZ_W-1:0]   hazard_cv_i,
  input  logic              zero_i,
  output logic [15:0]       instr_d_o,
  output logic [REG_AW-1:0] rs_i_o,
  output logic [REG_AW-1:0] rt_i_o,
  output logic [REG_AW-1:0] rs_e_o,
  output logic [REG_AW-1:0] rt_e_o,
  output logic [REG_AW-1:0] rs_m_o,
  output logic [REG_AW-1:0] write_reg_m_o,
  output logic [REG_AW-1:0] write_reg_w_o,
  output logic              reg_write_m_o,
  output logic              reg_write_w_o,
  output logic              mem_read_e_o,
  output logic [CV_W-1:0]   cv_e_o,
  output logic [CV_W-1:0]   cv_m_o,
  output logic [CV_W-1:0]   cv_w_o,
  output logic              pc_stall_o,
  output logic              pc_src_o,
  output logic              jump_o,
  output logic              stop_o
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);
  logic stop_q;
  logic fl_d, fl_e, fl_m;
  logic st_d, st_e, st_m, st_w;
  logic bb_e, bb_m, bb_w;
  logic [REG_AW-1:0] dst_id, dst_e;
  logic zero_m;
  logic unused_hz;
  assign unused_hz = ^hazard_cv_i[HZ_W-1:HZ_MEM_SRC];
  assign fl_d = hazard_cv_i[HZ_FLUSH_IF_ID] & ~stop_q;
  assign fl_e = hazard_cv_i[HZ_FLUSH_ID_EX] & ~stop_q;
  assign fl_m = hazard_cv_i[HZ_FLUSH_EX_MEM] & ~stop_q;
  assign st_d = hazard_cv_i[HZ_IF_ID_STALL] | hazard_cv_i[HZ_PCSTALL] | stop_q;
  assign st_e = hazard_cv_i[HZ_ID_EX_STALL] | stop_q;
  assign st_m = hazard_cv_i[HZ_EX_MEM_STALL] | stop_q;
  assign st_w = hazard_cv_i[HZ_MEM_WB_STALL] | stop_q;
  assign bb_e = st_d & ~fl_d & ~stop_q;
  assign bb_m = st_e & ~fl_e & ~stop_q;
  assign bb_w = st_m & ~fl_m & ~stop_q;
  assign dst_id = control_vector_i[CV_REG_DST_RT] ? instr_d_o[3:0] : instr_d_o[11:8];
  pipe_stage_reg #(.W(16), .RST_VAL(NOP_INSTR), .BUB_VAL(NOP_INSTR)) u_if_id (
    .clk(clk), .rst(rst), .flush(fl_d), .stall(st_d), .bubble(1'b0),
    .d(instr_i), .q(instr_d_o)
  );
  pipe_stage_reg #(.W(CV_W + 3*REG_AW)) u_id_ex (
    .clk(clk), .rst(rst), .flush(fl_e), .stall(st_e), .bubble(bb_e),
    .d({control_vector_i, instr_d_o[7:4], instr_d_o[3:0], dst_id}),
    .q({cv_e_o, rs_e_o, rt_e_o, dst_e})
  );
  pipe_stage_reg #(.W(CV_W + 2*REG_AW + 1)) u_ex_mem (
    .clk(clk), .rst(rst), .flush(fl_m), .stall(st_m), .bubble(bb_m),
    .d({cv_e_o, rs_e_o, dst_e, zero_i}),
    .q({cv_m_o, rs_m_o, write_reg_m_o, zero_m})
  );
  pipe_stage_reg #(.W(CV_W + REG_AW)) u_mem_wb (
    .clk(clk), .rst(rst), .flush(1'b0), .stall(st_w), .bubble(bb_w),
    .d({cv_m_o, write_reg_m_o}),
    .q({cv_w_o, write_reg_w_o})
  );
  always_ff @(posedge clk)
    stop_q <= rst ? 1'b0 : stop_q | cv_w_o[CV_STOP];
  assign rs_i_o = instr_d_o[7:4];
  assign rt_i_o = instr_d_o[3:0];
  assign reg_write_m_o = cv_m_o[CV_REG_WRITE];
  assign reg_write_w_o = cv_w_o[CV_REG_WRITE];
  assign mem_read_e_o = cv_e_o[CV_MEM_READ];
  assign pc_stall_o = hazard_cv_i[HZ_PCSTALL] | stop_q;
  assign pc_src_o = cv_m_o[CV_BRANCH] & zero_m;
  assign jump_o = cv_e_o[CV_BRANCH];
  assign stop_o = stop_q;
`ifdef PERF_CNT_EN
  logic ret_inc, bub_inc;
  assign ret_inc = ~st_w & ~bb_w & (cv_m_o != '0);
  assign bub_inc = fl_d | fl_e | fl_m | (bb_e & ~st_e) | (bb_m & ~st_m) | (bb_w & ~st_w);
  always_ff @(posedge clk) begin
    retired_cnt_o <= rst ? '0 : (ret_inc && ~&retired_cnt_o) ? retired_cnt_o + 32'd1 : retired_cnt_o;
    bubble_cnt_o <= rst ? '0 : (bub_inc && ~&bubble_cnt_o) ? bubble_cnt_o + 32'd1 : bubble_cnt_o;
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_regs.sv
// tb_pipe_hazard_regs: directed checks of forwarding tags, stall/flush bubbles, branch, stop freeze and reset
module tb_pipe_hazard_regs;
  import pipe_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] instr_i;
  logic [CV_W-1:0] control_vector_i;
  logic [HZ_W-1:0] hazard_cv_i;
  logic zero_i;
  logic [15:0] instr_d_o;
  logic [REG_AW-1:0] rs_i_o, rt_i_o, rs_e_o, rt_e_o, rs_m_o, write_reg_m_o, write_reg_w_o;
  logic reg_write_m_o, reg_write_w_o, mem_read_e_o;
  logic [CV_W-1:0] cv_e_o, cv_m_o, cv_w_o;
  logic pc_stall_o, pc_src_o, jump_o, stop_o;
  int total = 0;
  int bad = 0;
`ifdef PERF_CNT_EN
  logic [31:0] retired_cnt_o, bubble_cnt_o;
`endif
  pipe_hazard_regs dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .control_vector_i(control_vector_i),
    .hazard_cv_i(hazard_cv_i), .zero_i(zero_i), .instr_d_o(instr_d_o),
    .rs_i_o(rs_i_o), .rt_i_o(rt_i_o), .rs_e_o(rs_e_o), .rt_e_o(rt_e_o), .rs_m_o(rs_m_o),
    .write_reg_m_o(write_reg_m_o), .write_reg_w_o(write_reg_w_o),
    .reg_write_m_o(reg_write_m_o), .reg_write_w_o(reg_write_w_o), .mem_read_e_o(mem_read_e_o),
    .cv_e_o(cv_e_o), .cv_m_o(cv_m_o), .cv_w_o(cv_w_o), .pc_stall_o(pc_stall_o),
    .pc_src_o(pc_src_o), .jump_o(jump_o), .stop_o(stop_o)
`ifdef PERF_CNT_EN
    , .retired_cnt_o(retired_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  always_comb begin
    control_vector_i = 11'h000;
    case (instr_d_o[15:12])
      4'h0: control_vector_i = 11'h400;
      4'h1: control_vector_i = 11'h600;
      4'h2: control_vector_i = 11'h4C8;
      4'h4: control_vector_i = 11'h300;
      4'hE: control_vector_i = 11'h001;
      default: control_vector_i = 11'h000;
    endcase
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    instr_i = 16'hF000;
    hazard_cv_i = '0;
    zero_i = 1'b0;
    tick();
    tick();
    chk("rst_instr_d", 64'(instr_d_o), 64'hF000);
    chk("rst_cvs", {cv_e_o, cv_m_o, cv_w_o, write_reg_m_o, write_reg_w_o}, 64'h0);
    chk("rst_flags", {stop_o, pc_stall_o, pc_src_o, jump_o, reg_write_m_o, reg_write_w_o}, 64'h0);
    rst = 1'b0;
    // ADD r3 = r1 + r2, then SUB r4 = r3 - r5
    instr_i = 16'h0312;
    tick();
    chk("add_id", {instr_d_o, rs_i_o, rt_i_o}, {16'h0312, 4'd1, 4'd2});
    instr_i = 16'h1435;
    tick();
    chk("add_ex", {cv_e_o, jump_o}, {11'h400, 1'b0});
    instr_i = 16'hF000;
    tick();
    chk("fwd_tags", {write_reg_m_o, reg_write_m_o, rs_e_o, cv_e_o}, {4'd3, 1'b1, 4'd3, 11'h600});
    tick();
    chk("add_wb", {write_reg_w_o, reg_write_w_o, cv_m_o, write_reg_m_o}, {4'd3, 1'b1, 11'h600, 4'd4});
    tick();
    tick();
    tick();
    // LW r5 then dependent ADD: load-use stall
    instr_i = 16'h2015;
    tick();
    instr_i = 16'h0651;
    tick();
    chk("lw_ex", {cv_e_o, mem_read_e_o}, {11'h4C8, 1'b1});
    hazard_cv_i = 13'h0030;
    instr_i = 16'hF000;
    #1;
    chk("pcstall_out", 64'(pc_stall_o), 64'h1);
    tick();
    chk("loaduse", {instr_d_o, cv_e_o, cv_m_o, write_reg_m_o}, {16'h0651, 11'h000, 11'h4C8, 4'd5});
    hazard_cv_i = '0;
    tick();
    chk("loaduse_next", {rs_e_o, cv_e_o, write_reg_w_o, cv_m_o}, {4'd5, 11'h400, 4'd5, 11'h000});
    tick();
    tick();
    tick();
    // JMPZ taken
    instr_i = 16'h4023;
    tick();
    instr_i = 16'hF000;
    tick();
    zero_i = 1'b1;
    chk("jmp_ex", {jump_o, pc_src_o}, {1'b1, 1'b0});
    tick();
    chk("jmp_mem", {jump_o, pc_src_o, cv_m_o}, {1'b0, 1'b1, 11'h300});
    zero_i = 1'b0;
    hazard_cv_i = 13'h0080;
    tick();
    chk("flush_exmem", {cv_m_o, pc_src_o}, {11'h000, 1'b0});
    hazard_cv_i = '0;
    // flush and stall IF/ID together: flush wins
    instr_i = 16'h0312;
    tick();
    instr_i = 16'h1435;
    hazard_cv_i = 13'h0048;
    tick();
    chk("flush_over_stall", {instr_d_o, cv_e_o}, {16'hF000, 11'h400});
    hazard_cv_i = '0;
    // IF/ID stall inserts a single bubble into ID/EX
    instr_i = 16'h0789;
    tick();
    hazard_cv_i = 13'h0008;
    tick();
    chk("stall_bubble", {instr_d_o, cv_e_o}, {16'h0789, 11'h000});
    hazard_cv_i = '0;
    instr_i = 16'hF000;
    tick();
    chk("stall_release", {instr_d_o, cv_e_o, rs_e_o}, {16'hF000, 11'h400, 4'd8});
    tick();
    chk("no_dup", {cv_e_o, cv_m_o}, {11'h000, 11'h400});
    tick();
    tick();
    tick();
    // STOP reaches WB, pipeline freezes
    instr_i = 16'hE000;
    tick();
    instr_i = 16'h0312;
    tick();
    instr_i = 16'h1435;
    tick();
    instr_i = 16'hF000;
    tick();
    chk("stop_wb", {cv_w_o, stop_o}, {11'h001, 1'b0});
    tick();
    chk("stop_set", {stop_o, pc_stall_o, cv_w_o, write_reg_w_o, cv_m_o}, {1'b1, 1'b1, 11'h400, 4'd3, 11'h600});
    for (int i = 0; i < 10; i++) begin
      hazard_cv_i = 13'($urandom);
      instr_i = 16'($urandom);
      zero_i = 1'($urandom);
      tick();
      chk("freeze", {instr_d_o, cv_e_o, cv_m_o, write_reg_m_o, cv_w_o, write_reg_w_o, stop_o, pc_stall_o},
          {16'hF000, 11'h000, 11'h600, 4'd4, 11'h400, 4'd3, 1'b1, 1'b1});
    end
    hazard_cv_i = '0;
    instr_i = 16'hF000;
    zero_i = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_after_stop", {instr_d_o, cv_e_o, cv_m_o, cv_w_o, stop_o, pc_stall_o},
        {16'hF000, 11'h000, 11'h000, 11'h000, 1'b0, 1'b0});
    rst = 1'b0;
`ifdef PERF_CNT_EN
    instr_i = 16'h0312;
    tick();
    tick();
    tick();
    hazard_cv_i = 13'h0008;
    tick();
    hazard_cv_i = '0;
    tick();
    tick();
    instr_i = 16'hF000;
    for (int i = 0; i < 6; i++) tick();
    chk("perf_cnt", {retired_cnt_o, bubble_cnt_o}, {32'd5, 32'd1});
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
